// File: rtl/key_expand_ctrl_pkg.sv
// Shared constants, state encoding and S-box lookup
// for the AES-128 key expansion sequencer.
package key_expand_ctrl_pkg;

    localparam int BYTE    = 8;
    localparam int DWORD   = 32;
    localparam int LENGTH  = 128;
    localparam int NROUNDS = 10;

    localparam logic [7:0] RCON_POLY = 8'h1B;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EXPAND
    } state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(
        input logic [7:0] b
    );
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

endpackage

// File: rtl/key_expand_ctrl_subword.sv
// SubWord: byte-wise S-box substitution
// of one 32-bit word.
module key_expand_ctrl_subword
    import key_expand_ctrl_pkg::*;
(
    input  logic [DWORD-1:0] din,
    output logic [DWORD-1:0] dout
);

    for (genvar i = 0; i < DWORD/BYTE; i++) begin : g_sb
        assign dout[i*BYTE +: BYTE] =
            sbox(din[i*BYTE +: BYTE]);
    end

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer: one word per
// cycle, round keys 0..10 on a valid/ready stream.
module key_expand_ctrl
    import key_expand_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LENGTH-1:0] key,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [LENGTH-1:0] rk_data,
    output logic [3:0]        rk_round,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [DWORD-1:0] w0, w1, w2, w3;
    logic [3:0]       round;
    logic [7:0]       rcon;
    logic [1:0]       idx;

    logic [DWORD-1:0] rot;
    logic [DWORD-1:0] sub;
    logic [DWORD-1:0] temp;
    logic [DWORD-1:0] nw;
    logic [7:0]       rcon_nx;

    assign rot = {w3[23:0], w3[31:24]};

    key_expand_ctrl_subword u_sub (
        .din  (rot),
        .dout (sub)
    );

    // Next expanded word; only the first word of a
    // round goes through RotWord/SubWord/Rcon.
    always_comb begin
        temp = w3;
        if (idx == 2'd0)
            temp = sub ^ {rcon, 24'h0};
        nw = w0 ^ temp;
        rcon_nx = {rcon[6:0], 1'b0}
                ^ (rcon[7] ? RCON_POLY : 8'h00);
    end

    assign rk_data  = {w0, w1, w2, w3};
    assign rk_round = round;

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            round    <= '0;
            rcon     <= RCON_INIT;
            idx      <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w0       <= key[127:96];
                        w1       <= key[95:64];
                        w2       <= key[63:32];
                        w3       <= key[31:0];
                        round    <= '0;
                        rcon     <= RCON_INIT;
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (round == 4'(NROUNDS)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= EXPAND;
                            idx   <= '0;
                        end
                    end
                end
                EXPAND: begin
                    w0  <= w1;
                    w1  <= w2;
                    w2  <= w3;
                    w3  <= nw;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        round    <= round + 4'd1;
                        rcon     <= rcon_nx;
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
